// File: rtl/versat_rr_arbiter.sv
// -----------------------------------------------------------------------------
// versat_rr_arbiter
//
// Round-robin arbiter that shares one Versat datapath resource (memory port,
// FU configuration bus, ...) among N_REQ requesters.
//
// A requester that wins keeps the resource for as long as it holds its request
// high. When it drops the request, ownership moves to the next pending
// requester after it in circular order. If one is pending and en is high, the
// handoff completes on the same edge with no idle cycle in between.
//
// All outputs are registered, so gnt, gnt_idx and gnt_valid change on the same
// edge. Reset is asynchronous, so the outputs clear as soon as rst_n falls.
//
// Optional feature (compile-time macro ARB_HOLD_TIMEOUT_EN):
//   When defined, an owner that holds the grant for TIMEOUT cycles while
//   another requester is waiting is forced to hand over. The timeout output
//   pulses for one cycle alongside the new grant. When undefined, owners may
//   hold indefinitely and timeout is tied low.
//
// Parameters:
//   N_REQ    number of requesters (2..16)
//   IDX_W    width of gnt_idx, must equal $clog2(N_REQ)
//   TIMEOUT  hold limit in cycles under ARB_HOLD_TIMEOUT_EN (>= 2)
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   arbitration enable; low blocks new grants only
//   req        in   [N_REQ]  level request, bit i = requester i
//   gnt        out  [N_REQ]  registered one-hot grant, zero when idle
//   gnt_idx    out  [IDX_W]  binary index of the granted requester, 0 when idle
//   gnt_valid  out  high while any gnt bit is set
//   timeout    out  one-cycle pulse on a forced rotation
// -----------------------------------------------------------------------------
module versat_rr_arbiter #(
  parameter int N_REQ   = 4,
  parameter int IDX_W   = 2,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid,
  output logic             timeout
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (N_REQ < 2 || N_REQ > 16) begin : g_bad_n_req
    $error("versat_rr_arbiter: N_REQ must be in 2..16");
  end
  if (IDX_W != $clog2(N_REQ)) begin : g_bad_idx_w
    $error("versat_rr_arbiter: IDX_W must equal clog2(N_REQ)");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("versat_rr_arbiter: TIMEOUT must be >= 2");
  end

  // ---------------------------------------------------------------------------
  // State encoding and constants
  // ---------------------------------------------------------------------------
  localparam logic ST_IDLE  = 1'b0;  // no owner
  localparam logic ST_GRANT = 1'b1;  // exactly one owner

  // Resetting last_owner to the top requester makes the first search after
  // reset begin at requester 0.
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_REQ - 1);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic             state_q,     state_d;
  logic [N_REQ-1:0] gnt_q,       gnt_d;
  logic [IDX_W-1:0] gnt_idx_q,   gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0] last_q,      last_d;

  // ---------------------------------------------------------------------------
  // Internal signals
  // ---------------------------------------------------------------------------
  logic [N_REQ-1:0] search_req;   // candidates for this edge's search
  logic [IDX_W-1:0] search_base;  // search starts just after this index
  logic [IDX_W:0]   cand;         // one spare bit so base+k cannot overflow
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic             owner_req;    // current owner still requesting
  logic             force_rot;    // hold limit reached with others waiting
  logic             grant_new;    // a fresh grant is loaded this edge

  // gnt_q is one-hot on the owner, so masking with it drops the owner from
  // the search. That covers both a normal release and a forced rotation.
  // When idle, gnt_q is zero and every request is a candidate.
  assign search_req  = req & ~gnt_q;
  assign search_base = (state_q == ST_GRANT) ? gnt_idx_q : last_q;
  assign owner_req   = |(req & gnt_q);

  // Circular priority search: examine base+1, base+2, ..., base+N_REQ
  // (mod N_REQ) and take the first set request. Offsets stay below
  // 2*N_REQ, so a single conditional subtract is enough to wrap.
  always_comb begin
    // NOTE: every variable written here gets a default first. Without it,
    // some path through the block would leave a value unassigned and a
    // latch would be inferred.
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = {1'b0, search_base} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(N_REQ)) begin
        cand = cand - (IDX_W+1)'(N_REQ);
      end
      if (!win_found && search_req[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    last_d      = last_q;
    grant_new   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // win_found already implies req != 0.
        if (en && win_found) begin
          grant_new = 1'b1;
        end
      end

      ST_GRANT: begin
        // en is deliberately ignored while the owner keeps its request.
        // en only gates the choice of a successor.
        if (!owner_req || force_rot) begin
          last_d = gnt_idx_q;
          if (en && win_found) begin
            grant_new = 1'b1;  // back-to-back handoff
          end else begin
            state_d     = ST_IDLE;
            gnt_d       = '0;
            gnt_idx_d   = '0;
            gnt_valid_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (grant_new) begin
      state_d          = ST_GRANT;
      gnt_d            = '0;
      gnt_d[win_idx]   = 1'b1;
      gnt_idx_d        = win_idx;
      gnt_valid_d      = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      last_q      <= LAST_RST;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples the pre-edge values of the others. Blocking
      // assignments here would make the result depend on statement order.
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      last_q      <= last_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional hold timeout
  // ---------------------------------------------------------------------------
`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int               CNT_W   = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             timeout_q;
  logic             hold_grant;

  // The counter reads k during the k-th cycle of a grant, counting from 0.
  // Reaching CNT_MAX therefore means the owner has already had TIMEOUT
  // cycles. win_found here means another requester is waiting, because the
  // owner is masked out of the search.
  assign force_rot  = (state_q == ST_GRANT) && owner_req && win_found &&
                      (hold_cnt_q == CNT_MAX);
  assign hold_grant = (state_q == ST_GRANT) && owner_req && !force_rot;

  // The counter saturates while nobody else is waiting. A requester that
  // arrives later then triggers the rotation on the very next edge.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (grant_new) begin
      hold_cnt_d = '0;
    end else if (hold_grant && (hold_cnt_q != CNT_MAX)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= force_rot;
    end
  end

  assign timeout = timeout_q;
`else
  assign force_rot = 1'b0;
  assign timeout   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_versat_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_versat_rr_arbiter
//
// Self-checking bench for versat_rr_arbiter (N_REQ=4, TIMEOUT=4).
//
// The driver applies one (en, req) pair per clock. After each edge it advances
// a behavioural ownership model: owner, last owner and cycles held, tracked as
// plain integers. It then queues the outputs the model expects. A separate
// monitor pops one entry on every falling edge and compares it with the DUT.
// Directed sections add fixed-value checks of the documented scenarios, and
// the async-reset checks are made between clock edges.
// Build with +define+ARB_HOLD_TIMEOUT_EN to exercise the hold timeout.
// -----------------------------------------------------------------------------
module tb_versat_rr_arbiter;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int TO = 4;
`ifdef ARB_HOLD_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_idx;
  logic          gnt_valid;
  logic          timeout;

  versat_rr_arbiter #(
    .N_REQ   (N),
    .IDX_W   (IW),
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  gnt;
    logic [IW-1:0] idx;
    logic          valid;
    logic          to;
  } resp_t;

  resp_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: who owns the resource, who owned it last, and how many
  // cycles the current owner has held it.
  // ---------------------------------------------------------------------------
  int m_owner;  // -1 when idle
  int m_last;
  int m_held;
  bit m_to;

  function automatic int pick(input logic [N-1:0] r, input int after);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (after + k) % N;
      if (r[IW'(c)]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_held  = 0;
    m_to    = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic [N-1:0] r);
    m_to = 1'b0;
    if (m_owner < 0) begin
      if (e && r != '0) begin
        m_owner = pick(r, m_last);
        m_held  = 1;
      end
    end else begin
      logic [N-1:0] others;
      bit keep, forced;
      others = r & ~(N'(1) << m_owner);
      keep   = r[IW'(m_owner)];
      forced = TO_EN && keep && (others != '0) && (m_held >= TO);
      if (keep && !forced) begin
        if (m_held < TO) m_held++;
      end else begin
        m_to   = forced;
        m_last = m_owner;
        if (e && others != '0) begin
          m_owner = pick(others, m_last);
          m_held  = 1;
        end else begin
          m_owner = -1;
        end
      end
    end
  endtask

  function automatic resp_t model_resp();
    resp_t x;
    x = '0;
    if (m_owner >= 0) begin
      x.gnt   = N'(1) << m_owner;
      x.idx   = IW'(m_owner);
      x.valid = 1'b1;
    end
    x.to = m_to;
    return x;
  endfunction

  // Drive one (en, req) pair, let one rising edge sample it, then queue the
  // model's expectation. Returns 1 time unit after the edge.
  task automatic step(input logic e, input logic [N-1:0] r);
    en  = e;
    req = r;
    @(posedge clk);
    #1;
    model_step(e, r);
    exp_q.push_back(model_resp());
  endtask

  task automatic expect_out(input string name, input logic [N-1:0] g,
                            input logic [IW-1:0] i, input logic v);
    check({name, "_gnt"},   gnt,       g);
    check({name, "_idx"},   gnt_idx,   i);
    check({name, "_valid"}, gnt_valid, v);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  initial begin : monitor
    resp_t want;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        check("sb_gnt",     gnt,       want.gnt);
        check("sb_idx",     gnt_idx,   want.idx);
        check("sb_valid",   gnt_valid, want.valid);
        check("sb_timeout", timeout,   want.to);
        check("sb_onehot0", $onehot0(gnt), 1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : driver
    logic [N-1:0] rnd_req;

    en    = 1'b0;
    req   = '0;
    rst_n = 1'b1;
    model_reset();
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("reset", 4'b0000, 2'd0, 1'b0);
    check("reset_timeout", timeout, 0);
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;

    // Async reset mid-grant: outputs clear with no clock edge.
    step(1'b1, 4'b0100);
    expect_out("pre_rst", 4'b0100, 2'd2, 1'b1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 4'b0000, 2'd0, 1'b0);
    check("async_rst_timeout", timeout, 0);
    model_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    step(1'b1, 4'b1111);
    expect_out("first_after_rst", 4'b0001, 2'd0, 1'b1);

    // Fair rotation: each owner drops its request for one cycle.
    step(1'b1, 4'b1110);
    expect_out("rot1", 4'b0010, 2'd1, 1'b1);
    step(1'b1, 4'b1101);
    expect_out("rot2", 4'b0100, 2'd2, 1'b1);
    step(1'b1, 4'b1011);
    expect_out("rot3", 4'b1000, 2'd3, 1'b1);
    step(1'b1, 4'b0111);
    expect_out("rot4", 4'b0001, 2'd0, 1'b1);

    // Hold and ignore: owner 2 keeps its request while 0 and 3 wait.
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0100);
    expect_out("hold_start", 4'b0100, 2'd2, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'b1101);
`ifndef ARB_HOLD_TIMEOUT_EN
      check("hold_gnt", gnt, 4'b0100);
`endif
    end
    step(1'b1, 4'b1001);
`ifndef ARB_HOLD_TIMEOUT_EN
    expect_out("hold_release", 4'b1000, 2'd3, 1'b1);
`endif

    // Enable gating.
    step(1'b1, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b0010);
      expect_out("en_low_idle", 4'b0000, 2'd0, 1'b0);
    end
    step(1'b1, 4'b0010);
    expect_out("en_high", 4'b0010, 2'd1, 1'b1);
    step(1'b0, 4'b0010);
    step(1'b0, 4'b0010);
    expect_out("en_low_hold", 4'b0010, 2'd1, 1'b1);
    step(1'b0, 4'b0000);
    expect_out("en_low_release", 4'b0000, 2'd0, 1'b0);

    // Single requester toggling.
    step(1'b1, 4'b0001);
    expect_out("single_on", 4'b0001, 2'd0, 1'b1);
    step(1'b1, 4'b0000);
    expect_out("single_off", 4'b0000, 2'd0, 1'b0);
    step(1'b1, 4'b0001);
    expect_out("single_again", 4'b0001, 2'd0, 1'b1);

`ifdef ARB_HOLD_TIMEOUT_EN
    // Forced rotation after TO grant cycles while requester 3 waits.
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0010);
    expect_out("to_start", 4'b0010, 2'd1, 1'b1);
    for (int i = 0; i < TO - 1; i++) begin
      step(1'b1, 4'b1010);
      check("to_hold_gnt", gnt, 4'b0010);
      check("to_hold_pulse", timeout, 0);
    end
    step(1'b1, 4'b1010);
    expect_out("to_forced", 4'b1000, 2'd3, 1'b1);
    check("to_pulse", timeout, 1);
    step(1'b1, 4'b1010);
    check("to_pulse_end", timeout, 0);
    // No one else waiting: the owner keeps the grant.
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0010);
    for (int i = 0; i < 2 * TO; i++) begin
      step(1'b1, 4'b0010);
      check("to_alone_gnt", gnt, 4'b0010);
      check("to_alone_pulse", timeout, 0);
    end
`endif

    // Randomised traffic: requests toggle occasionally, en is mostly high.
    rnd_req = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(5) == 0) rnd_req[b] = ~rnd_req[b];
      end
      step($urandom_range(7) != 0, rnd_req);
    end

    // Let the monitor drain what is queued, within a bounded wait.
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
      @(negedge clk);
    end
    #1;
    check("sb_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
